alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_if.sv | 27 ++
 rtl/alu_mc.sv | 160 ++++++++++++++++
 tb/tb_alu_mc.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle ALU.
// The master drives requests and accepts results; the slave is the ALU itself.
interface alu_mc_if #(
   parameter int WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic [3:0]           select;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   result;
   logic                 carry;
   logic                 zflag;
   logic                 illegal;

   modport master (
      output in_valid, A, B, select, out_ready,
      input  in_ready, out_valid, result, carry, zflag, illegal
   );

   modport slave (
      input  in_valid, A, B, select, out_ready,
      output in_ready, out_valid, result, carry, zflag, illegal
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, WIDTH-cycle shift-add
// multiply. One request in flight; the result is held in DONE until consumed.
module alu_mc #(
   parameter int WIDTH = 8
) (
   input  logic    clk,
   input  logic    rst,
   alu_mc_if.slave bus
);
   localparam int SW = $clog2(WIDTH) + 1;   // shift amount width, B[$clog2(WIDTH):0]
   localparam int CW = $clog2(WIDTH + 1);   // multiplier bit counter width

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_NAND = 4'd5;
   localparam logic [3:0] OP_NOR  = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;

   typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

   state_t               state;
   state_t               state_next;
   logic                 in_ready;
   logic                 out_valid;

   logic [2*WIDTH-1:0]   mul_a;     // multiplicand, shifted left each step
   logic [WIDTH-1:0]     mul_b;     // multiplier, shifted right each step
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   mul_sum;
   logic                 mult_last;

   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       diff;
   logic [SW-1:0]        sh;
   logic [WIDTH:0]       shr_ext;   // A with one guard bit below: bit 0 is the last bit shifted out
   logic [2*WIDTH-1:0]   alu_res;
   logic                 alu_carry;
   logic                 alu_illegal;

   logic [2*WIDTH-1:0]   res_q;
   logic                 carry_q;
   logic                 zflag_q;
   logic                 illegal_q;

   assign sum       = {1'b0, bus.A} + {1'b0, bus.B};
   assign diff      = {1'b0, bus.A} - {1'b0, bus.B};   // diff[WIDTH] is the borrow
   assign sh        = bus.B[SW-1:0];
   assign shr_ext   = {bus.A, 1'b0} >> sh;
   assign mul_sum   = acc + (mul_b[0] ? mul_a : '0);
   assign mult_last = (cnt == CW'(WIDTH - 1));

   // Single-cycle ops evaluated straight off the request so they load on the accept edge.
   always_comb begin
      alu_res     = '0;
      alu_carry   = 1'b0;
      alu_illegal = 1'b0;
      case (bus.select)
         OP_ADD: begin
            alu_res   = {{(WIDTH-1){1'b0}}, sum};
            alu_carry = sum[WIDTH];
         end
         OP_SUB: begin
            alu_res   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
            alu_carry = diff[WIDTH];
         end
         OP_MUL:  alu_res = '0;   // produced by the MULT sequence instead
         OP_AND:  alu_res = {{WIDTH{1'b0}}, bus.A & bus.B};
         OP_OR:   alu_res = {{WIDTH{1'b0}}, bus.A | bus.B};
         OP_NAND: alu_res = {{WIDTH{1'b0}}, ~(bus.A & bus.B)};
         OP_NOR:  alu_res = {{WIDTH{1'b0}}, ~(bus.A | bus.B)};
         OP_XOR:  alu_res = {{WIDTH{1'b0}}, bus.A ^ bus.B};
         OP_SHL:  alu_res = {{WIDTH{1'b0}}, bus.A} << sh;
         OP_SHR: begin
            alu_res   = {{WIDTH{1'b0}}, shr_ext[WIDTH:1]};
            alu_carry = shr_ext[0];
         end
         default: alu_illegal = 1'b1;
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_next = (bus.select == OP_MUL) ? MULT : DONE;
         end
         MULT: begin
            if (mult_last) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Shift-add multiplier: one multiplier bit per cycle, always WIDTH steps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_a <= '0;
         mul_b <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else if (state == IDLE && bus.in_valid && bus.select == OP_MUL) begin
         mul_a <= {{WIDTH{1'b0}}, bus.A};
         mul_b <= bus.B;
         acc   <= '0;
         cnt   <= '0;
      end else if (state == MULT) begin
         acc   <= mul_sum;
         mul_a <= mul_a << 1;
         mul_b <= mul_b >> 1;
         cnt   <= cnt + CW'(1);
      end
   end

   // Result registers: loaded on a single-cycle accept or the last multiply step, held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q     <= '0;
         carry_q   <= 1'b0;
         zflag_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else if (state == IDLE && bus.in_valid && bus.select != OP_MUL) begin
         res_q     <= alu_res;
         carry_q   <= alu_carry;
         zflag_q   <= (alu_res == '0);
         illegal_q <= alu_illegal;
      end else if (state == MULT && mult_last) begin
         res_q     <= mul_sum;
         carry_q   <= 1'b0;
         zflag_q   <= (mul_sum == '0);
         illegal_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.result    = res_q;
   assign bus.carry     = carry_q;
   assign bus.zflag     = zflag_q;
   assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=8): directed vectors with literal expectations plus a
// scoreboard that checks every valid output cycle against an arithmetic model.
module tb_alu_mc;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   alu_mc_if #(.WIDTH(8)) bus();

   alu_mc #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] r;
      logic        c;
      logic        z;
      logic        il;
   } exp_t;

   // Behavioural model: plain integer arithmetic on the opcode rules.
   function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      exp_t        e;
      int unsigned ua, ub, s, r;
      ua = a; ub = b; s = ub % 16; r = 0;
      e.c = 1'b0; e.il = 1'b0;
      case (op)
         4'd0: begin r = ua + ub; e.c = (r > 255); end
         4'd1: begin r = (ua + 256 - ub) % 256; e.c = (ua < ub); end
         4'd2: r = ua * ub;
         4'd3: r = ua & ub;
         4'd4: r = ua | ub;
         4'd5: r = (~(ua & ub)) & 255;
         4'd6: r = (~(ua | ub)) & 255;
         4'd7: r = ua ^ ub;
         4'd8: r = (ua << s) % 65536;
         4'd9: begin
            r = ua >> s;
            e.c = (s > 0 && s <= 8) ? 1'((ua >> (s - 1)) & 1) : 1'b0;
         end
         default: e.il = 1'b1;
      endcase
      e.r = r[15:0];
      e.z = (e.r == 16'h0);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Scoreboard: queue expectations at accept, check every out_valid cycle.
   exp_t        q[$];
   logic        pv, pr;
   logic [15:0] pres;
   logic        pc, pz, pil;
   initial pv = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         pv = 1'b0;
      end else begin
         if (bus.out_valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL spurious_out_valid result=%h with no request outstanding", bus.result);
            end else begin
               if (bus.result !== q[0].r || bus.carry !== q[0].c || bus.zflag !== q[0].z || bus.illegal !== q[0].il) begin
                  errors++;
                  $display("FAIL model_compare got r=%h c=%b z=%b il=%b expected r=%h c=%b z=%b il=%b",
                           bus.result, bus.carry, bus.zflag, bus.illegal, q[0].r, q[0].c, q[0].z, q[0].il);
               end
               if (bus.out_ready) void'(q.pop_front());
            end
            if (pv && !pr) begin
               checks++;
               if (bus.result !== pres || bus.carry !== pc || bus.zflag !== pz || bus.illegal !== pil) begin
                  errors++;
                  $display("FAIL hold_stable got r=%h c=%b z=%b il=%b expected r=%h c=%b z=%b il=%b",
                           bus.result, bus.carry, bus.zflag, bus.illegal, pres, pc, pz, pil);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) q.push_back(model(bus.select, bus.A, bus.B));
         pv = bus.out_valid; pr = bus.out_ready;
         pres = bus.result; pc = bus.carry; pz = bus.zflag; pil = bus.illegal;
      end
   end

   // Issue one request from IDLE; report latency to out_valid, busy cycles and the result.
   task automatic run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input int hold,
                      output int lat, output int busy, output exp_t got);
      int held;
      held = 0; lat = 0; busy = 0;
      got.r = 'x; got.c = 'x; got.z = 'x; got.il = 'x;
      bus.out_ready = (hold == 0);
      bus.in_valid  = 1'b1;
      bus.A = a; bus.B = b; bus.select = op;
      @(posedge clk); #1;
      // scramble inputs: the captured operation must not notice
      bus.in_valid = 1'b0;
      bus.A = ~a; bus.B = ~b; bus.select = op ^ 4'h5;
      while (!bus.in_ready && busy < 100) begin
         busy++;
         if (bus.out_valid && lat == 0) begin
            lat = busy;
            got.r = bus.result; got.c = bus.carry; got.z = bus.zflag; got.il = bus.illegal;
         end
         if (bus.out_valid) begin
            if (held >= hold) bus.out_ready = 1'b1;
            else held++;
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
   endtask

   task automatic vec(input string name, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input int hold, input logic [15:0] er, input logic ec, input logic ez,
                      input logic eil, input int elat);
      int   lat, busy;
      exp_t got;
      run(op, a, b, hold, lat, busy, got);
      chk({name, "_lat"},  lat,  elat);
      chk({name, "_busy"}, busy, elat + hold);
      chk({name, "_res"},  {13'h0, got.il, got.z, got.c, got.r}, {13'h0, eil, ez, ec, er});
   endtask

   initial begin
      int bad;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.A = '0; bus.B = '0; bus.select = '0;
      #2;
      chk("reset_in_ready",  bus.in_ready,  1);
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_outputs", {bus.illegal, bus.zflag, bus.carry, bus.result}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // name, op, A, B, hold, result, carry, zflag, illegal, latency
      vec("add_ff_01",  4'd0, 8'hFF, 8'h01, 0, 16'h0100, 1, 0, 0, 1);
      vec("sub_eq",     4'd1, 8'h05, 8'h05, 0, 16'h0000, 0, 1, 0, 1);
      vec("sub_borrow", 4'd1, 8'h03, 8'h05, 0, 16'h00FE, 1, 0, 0, 1);
      vec("mul_ff_ff",  4'd2, 8'hFF, 8'hFF, 0, 16'hFE01, 0, 0, 0, 9);
      vec("mul_zero",   4'd2, 8'h00, 8'h7F, 0, 16'h0000, 0, 1, 0, 9);
      vec("mul_0d_0b",  4'd2, 8'h0D, 8'h0B, 2, 16'h008F, 0, 0, 0, 9);
      vec("nand_stall", 4'd5, 8'hFF, 8'hFF, 5, 16'h0000, 0, 1, 0, 1);
      vec("illegal_c",  4'hC, 8'h12, 8'h34, 0, 16'h0000, 0, 1, 1, 1);
      vec("illegal_f",  4'hF, 8'hFF, 8'hFF, 1, 16'h0000, 0, 1, 1, 1);
      vec("shr_81_1",   4'd9, 8'h81, 8'h01, 0, 16'h0040, 1, 0, 0, 1);
      vec("shr_80_8",   4'd9, 8'h80, 8'h08, 0, 16'h0000, 1, 1, 0, 1);
      vec("shr_zero",   4'd9, 8'h81, 8'h10, 0, 16'h0081, 0, 0, 0, 1);
      vec("shl_81_4",   4'd8, 8'h81, 8'h04, 0, 16'h0810, 0, 0, 0, 1);
      vec("shl_81_15",  4'd8, 8'h81, 8'h0F, 0, 16'h8000, 0, 0, 0, 1);
      vec("and",        4'd3, 8'hF0, 8'h3C, 0, 16'h0030, 0, 0, 0, 1);
      vec("or",         4'd4, 8'hF0, 8'h3C, 0, 16'h00FC, 0, 0, 0, 1);
      vec("nor",        4'd6, 8'hF0, 8'h0F, 0, 16'h0000, 0, 1, 0, 1);
      vec("xor",        4'd7, 8'hA5, 8'h5A, 0, 16'h00FF, 0, 0, 0, 1);

      // reset in the middle of a multiply: immediate IDLE and no result afterwards
      bus.in_valid = 1'b1; bus.select = 4'd2; bus.A = 8'hFF; bus.B = 8'hFF;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_mult_out_valid", bus.out_valid, 0);
      chk("rst_mid_mult_in_ready",  bus.in_ready,  1);
      @(posedge clk); #1;
      rst = 1'b0;
      bad = 0;
      repeat (12) begin
         if (bus.out_valid || !bus.in_ready) bad++;
         @(posedge clk); #1;
      end
      chk("rst_abort_quiet", bad, 0);
      vec("add_after_rst", 4'd0, 8'h12, 8'h34, 0, 16'h0046, 0, 0, 0, 1);

      @(posedge clk); #1;
      chk("scoreboard_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
